instr_issue_sequencer: RTL and testbench

INSTR_ISSUE_SEQUENCER -- requirements
Module: instr_issue_sequencer

---
 rtl/instr_issue_sequencer_pkg.sv | 39 +++
 rtl/instr_issue_sequencer_fifo.sv | 47 ++++
 rtl/instr_issue_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_issue_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_sequencer_pkg.sv
// Shared definitions for the instruction issue sequencer: opcode values,
// instruction field positions, FSM state encoding and the MAC word builder.
package instr_issue_sequencer_pkg;

    // Instruction field positions
    localparam int OP_MSB   = 63;
    localparam int OP_LSB   = 59;
    localparam int ADDR_MSB = 58;
    localparam int ADDR_LSB = 43;
    localparam int DATA_MSB = 42;
    localparam int DATA_LSB = 27;
    localparam int CNT_MSB  = 42;
    localparam int CNT_LSB  = 35;

    // Opcodes
    localparam logic [4:0] OP_NOP       = 5'b00000;
    localparam logic [4:0] OP_MAC       = 5'b00001;
    localparam logic [4:0] OP_PASS_02   = 5'b00010;
    localparam logic [4:0] OP_STORE_OUT = 5'b00011;
    localparam logic [4:0] OP_PASS_04   = 5'b00100;
    localparam logic [4:0] OP_PASS_05   = 5'b00101;
    localparam logic [4:0] OP_TX_OUT    = 5'b00110;
    localparam logic [4:0] OP_PASS_07   = 5'b00111;
    localparam logic [4:0] OP_MAC_BURST = 5'b01000;
    localparam logic [4:0] OP_END       = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_BURST    = 2'd2,
        ST_HAZ_WAIT = 2'd3
    } state_t;

    // One expanded burst element: MAC opcode, target address, no payload.
    function automatic logic [63:0] make_mac(input logic [15:0] addr);
        return {OP_MAC, addr, 43'b0};
    endfunction

endpackage

// File: rtl/instr_issue_sequencer_fifo.sv
// Synchronous show-ahead FIFO. Full and empty are told apart by one extra
// pointer bit; DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer update; a simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until covered by the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Instruction issue sequencer: queues incoming 64-bit instructions, expands
// MAC bursts, drops NOP/END, and keeps Transmit Output a fixed number of
// cycles behind a Store Output to the same output-buffer address.
// Handshake: a push happens on a rising edge where in_valid and in_ready
// are both high; in_ready reflects only the registered full flag, so a pop
// in the same cycle never opens a slot early.
module instr_issue_sequencer
    import instr_issue_sequencer_pkg::*;
#(
    parameter int QDEPTH  = 4,
    parameter int HAZ_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    output logic [63:0] out_instr,
    output logic        busy,
    output state_t      dbg_state
);
    localparam logic [7:0] HAZ_LOAD = 8'(HAZ_GAP);

    logic [63:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_op;
    logic [15:0] w_addr;
    logic [7:0]  w_cnt;
    logic        w_haz_block;

    state_t      r_state;
    logic [63:0] r_out;
    logic [15:0] r_burst_addr;
    logic [7:0]  r_burst_left;
    logic [7:0]  r_haz_cnt;
    logic [3:0]  r_haz_addr;

    sync_fifo #(.WIDTH(64), .DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_instr),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_op   = w_head[OP_MSB:OP_LSB];
    assign w_addr = w_head[ADDR_MSB:ADDR_LSB];
    assign w_cnt  = w_head[CNT_MSB:CNT_LSB];

    // Transmit Output must wait while a recent Store Output to the same
    // address is still inside its protection window.
    assign w_haz_block = (w_op == OP_TX_OUT) && (w_addr[3:0] == r_haz_addr) &&
                         (r_haz_cnt != 8'd0);

    assign in_ready  = !rst && !w_full;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_state == ST_ISSUE) && !stall && !w_empty && !w_haz_block;
    assign out_instr = r_out;
    assign busy      = !rst && (!w_empty || (r_state == ST_BURST) ||
                                (r_state == ST_HAZ_WAIT));
    assign dbg_state = r_state;

    // Hazard window: armed by an issued Store Output, then counts down every
    // cycle (stalled or not) and rests at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_haz_cnt  <= '0;
            r_haz_addr <= '0;
        end else if (w_pop && (w_op == OP_STORE_OUT)) begin
            r_haz_cnt  <= HAZ_LOAD;
            r_haz_addr <= w_addr[3:0];
        end else if (r_haz_cnt != 8'd0) begin
            r_haz_cnt <= r_haz_cnt - 8'd1;
        end
    end

    // Issue FSM with registered output; anything not explicitly emitted is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_out        <= '0;
            r_burst_addr <= '0;
            r_burst_left <= '0;
        end else begin
            r_out <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        if (w_empty) begin
                            r_state <= ST_IDLE;
                        end else if (w_haz_block) begin
                            // With one cycle left the window closes this cycle,
                            // so the head can go next cycle without HAZ_WAIT.
                            r_state <= (r_haz_cnt == 8'd1) ? ST_ISSUE : ST_HAZ_WAIT;
                        end else begin
                            case (w_op)
                                OP_NOP, OP_END: r_out <= '0;
                                OP_MAC_BURST: begin
                                    // First element leaves with the pop; the
                                    // rest are walked out in BURST.
                                    if (w_cnt != 8'd0) begin
                                        r_out <= make_mac(w_addr);
                                        if (w_cnt != 8'd1) begin
                                            r_burst_addr <= w_addr + 16'd1;
                                            r_burst_left <= w_cnt - 8'd1;
                                            r_state      <= ST_BURST;
                                        end
                                    end
                                end
                                default: r_out <= w_head;
                            endcase
                        end
                    end
                end
                ST_BURST: begin
                    if (!stall) begin
                        r_out        <= make_mac(r_burst_addr);
                        r_burst_addr <= r_burst_addr + 16'd1;
                        r_burst_left <= r_burst_left - 8'd1;
                        if (r_burst_left == 8'd1)
                            r_state <= w_empty ? ST_IDLE : ST_ISSUE;
                    end
                end
                ST_HAZ_WAIT: begin
                    if (r_haz_cnt <= 8'd1) r_state <= ST_ISSUE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench for instr_issue_sequencer: directed scenarios with
// literal timing checks plus a stream scoreboard fed by an opcode-level model.
module tb_instr_issue_sequencer;
    import instr_issue_sequencer_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        in_valid = 1'b0;
    logic        stall    = 1'b0;
    logic [63:0] in_instr = '0;
    logic        in_ready;
    logic        busy;
    logic [63:0] out_instr;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic mon_rst;
    logic mon_stall;

    always #5 clk = ~clk;

    instr_issue_sequencer #(.QDEPTH(4), .HAZ_GAP(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .out_instr (out_instr),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- helpers / model ----------------
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [15:0] addr,
                                       input logic [15:0] data);
        return {op, addr, data, 27'b0};
    endfunction

    function automatic logic [63:0] mac_of(input logic [15:0] addr);
        return {5'b00001, addr, 43'b0};
    endfunction

    // What an accepted instruction must eventually put on out_instr, in order.
    function automatic void model_push(input logic [63:0] ins);
        logic [4:0]  op = ins[63:59];
        logic [15:0] a  = ins[58:43];
        logic [7:0]  c  = ins[42:35];
        if (op == 5'b00000 || op == 5'b11111) return;
        if (op == 5'b01000) begin
            for (int i = 0; i < int'(c); i++) exp_q.push_back(mac_of(a + 16'(i)));
            return;
        end
        exp_q.push_back(ins);
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic push(input logic [63:0] ins, output bit acc);
        in_instr = ins;
        in_valid = 1'b1;
        #1;
        acc = in_ready;
        if (acc) model_push(ins);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_ok(input logic [63:0] ins, input string name);
        bit acc;
        push(ins, acc);
        check64(name, 64'(acc), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check64(name, 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic measure_gap(input logic [63:0] first, input logic [63:0] second,
                               input int exp_gap, input string name);
        int i_first  = -1;
        int i_second = -1;
        for (int i = 1; i <= 30 && i_second < 0; i++) begin
            @(negedge clk);
            if (out_instr === first && i_first < 0)   i_first = i;
            if (out_instr === second && i_second < 0) i_second = i;
        end
        check64({name, "_seen"}, 64'(i_first >= 0 && i_second >= 0), 64'd1);
        check64({name, "_gap"}, 64'(i_second - i_first - 1), 64'(exp_gap));
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(posedge clk) begin
        mon_rst   = rst;
        mon_stall = stall;
        #1;
        if (mon_rst) begin
            check64("rst_out_zero", out_instr, 64'h0);
            exp_q.delete();
        end else if (mon_stall) begin
            check64("stall_out_zero", out_instr, 64'h0);
        end else if (out_instr != 64'h0) begin
            if (exp_q.size() == 0) check64("unexpected_out", out_instr, 64'h0);
            else                   check64("stream_order", out_instr, exp_q.pop_front());
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit          acc;
        logic [63:0] d_vec [5];
        logic [63:0] s3, t3, s3b, t4;
        bit   [11:0] stall_pat;

        d_vec[0] = mk(5'b00101, 16'h0001, 16'hA001);
        d_vec[1] = mk(5'b00111, 16'h0002, 16'hA002);
        d_vec[2] = mk(5'b00010, 16'h0003, 16'hA003);
        d_vec[3] = mk(5'b10101, 16'h0004, 16'hA004);
        d_vec[4] = mk(5'b00100, 16'h0005, 16'hA005);

        // Reset state
        repeat (2) @(negedge clk);
        check64("rst_out", out_instr, 64'h0);
        check64("rst_in_ready", 64'(in_ready), 64'd0);
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        #1;
        check64("ready_after_reset", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Single pass-through instruction: visible exactly 2 cycles after push
        push_ok(mk(5'b00100, 16'd5, 16'h1234), "s1_accept");
        check64("s1_c0", out_instr, 64'h0);
        @(negedge clk); check64("s1_c1", out_instr, 64'h0);
        @(negedge clk); check64("s1_c2", out_instr, 64'h2000_2891_A000_0000);
        @(negedge clk); check64("s1_c3", out_instr, 64'h0);

        // MAC burst wrapping the 16-bit address
        push_ok(mk(5'b01000, 16'hFFFE, {8'd3, 8'h00}), "s2_accept");
        @(negedge clk);
        @(negedge clk); check64("s2_e0", out_instr, 64'h0FFF_F000_0000_0000);
        @(negedge clk); check64("s2_e1", out_instr, 64'h0FFF_F800_0000_0000);
        check64("s2_busy_mid", 64'(busy), 64'd1);
        @(negedge clk); check64("s2_e2", out_instr, 64'h0800_0000_0000_0000);
        check64("s2_busy_end", 64'(busy), 64'd0);
        @(negedge clk); check64("s2_after", out_instr, 64'h0);

        // Store/Transmit hazard: same address -> 2 bubbles, other address -> none
        s3  = mk(5'b00011, 16'h0003, 16'h00AA);
        t3  = mk(5'b00110, 16'h0003, 16'h0055);
        push_ok(s3, "s3_store");
        push_ok(t3, "s3_tx");
        measure_gap(s3, t3, 2, "haz_same");
        wait_idle("s3_idle");
        s3b = mk(5'b00011, 16'h0003, 16'h00BB);
        t4  = mk(5'b00110, 16'h0004, 16'h0066);
        push_ok(s3b, "s3b_store");
        push_ok(t4, "s3b_tx");
        measure_gap(s3b, t4, 0, "haz_diff");
        wait_idle("s3b_idle");

        // Fill under stall, then drain in order
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push_ok(d_vec[i], "s4_fill");
        push(d_vec[4], acc);
        check64("s4_full_reject", 64'(acc), 64'd0);
        check64("s4_ready_full", 64'(in_ready), 64'd0);
        check64("s4_out_stalled", out_instr, 64'h0);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check64("s4_order", out_instr, d_vec[i]);
            if (i == 0) check64("s4_ready_after_pop", 64'(in_ready), 64'd1);
        end
        wait_idle("s4_idle");

        // Reset in the middle of a 10-element burst
        push_ok(mk(5'b01000, 16'h0000, {8'd10, 8'h00}), "s5_accept");
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check64("s5_burst", out_instr, mac_of(16'(i)));
        end
        check64("s5_pin_e3", out_instr, 64'h0800_1800_0000_0000);
        rst = 1'b1;
        push(mk(5'b00100, 16'h00FF, 16'hBEEF), acc);
        check64("s5_push_in_reset", 64'(acc), 64'd0);
        check64("s5_out", out_instr, 64'h0);
        check64("s5_busy", 64'(busy), 64'd0);
        check64("s5_state", 64'(dbg_state), 64'(ST_IDLE));
        check64("s5_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check64("s5_quiet", out_instr, 64'h0);
        end
        check64("s5_sb_flushed", 64'(exp_q.size()), 64'd0);

        // Dropped opcodes drain in 3 cycles with nothing emitted
        push_ok(mk(5'b11111, 16'h1234, 16'h5678), "s6_end");
        push_ok(mk(5'b00000, 16'h0000, 16'h0042), "s6_nop");
        push_ok(mk(5'b01000, 16'h0007, 16'h0000), "s6_burst0");
        check64("s6_busy_c0", 64'(busy), 64'd1);
        check64("s6_out_c0", out_instr, 64'h0);
        @(negedge clk);
        check64("s6_busy_c1", 64'(busy), 64'd1);
        check64("s6_out_c1", out_instr, 64'h0);
        @(negedge clk);
        check64("s6_busy_c2", 64'(busy), 64'd0);
        check64("s6_out_c2", out_instr, 64'h0);

        // Mixed stream under an irregular stall pattern
        push_ok(mk(5'b01000, 16'h0010, {8'd4, 8'h00}), "s7_burst");
        push_ok(mk(5'b00011, 16'h0009, 16'h0101), "s7_store");
        push_ok(mk(5'b00110, 16'h0009, 16'h0202), "s7_tx");
        push_ok(mk(5'b00111, 16'h0ABC, 16'h1357), "s7_pass");
        stall_pat = 12'b0110_0101_1010;
        for (int i = 0; i < 12; i++) begin
            stall = stall_pat[i];
            @(negedge clk);
        end
        stall = 1'b0;
        wait_idle("s7_idle");
        repeat (3) @(negedge clk);

        check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
